// File: rtl/scan_code_gen.sv
// -----------------------------------------------------------------------------
// scan_code_gen
//
// Produces the 3-bit select code for a downstream 3-to-8 decoder used in
// LED/digit scanning. The code walks through 0..last either automatically on a
// prescaled tick (RUN) or once per rising edge of step_req (STEP). Counting
// direction and the top of the range may change between advances.
//
// Parameters
//   CLK_DIV     clk cycles per auto-advance tick, legal range 2..2^24
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   en          in   1  block enable; 0 holds the code and clears the prescaler
//   step_mode   in   1  0 = auto-advance on tick, 1 = advance on step_req edge
//   step_req    in   1  manual step request, rising-edge detected internally
//   dir         in   1  0 = count up, 1 = count down
//   last        in   3  highest code of the scan range
//   code_out    out  3  current select code (decoder data_in)
//   code_valid  out  1  strobe in the cycle code_out takes a new value
//   tick        out  1  prescaler strobe, high while the count sits at CLK_DIV-1
// -----------------------------------------------------------------------------
module scan_code_gen #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step_mode,
  input  logic       step_req,
  input  logic       dir,
  input  logic [2:0] last,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       tick
);

  // Terminal prescaler count; CLK_DIV = 2^24 still fits in 24 bits after -1.
  localparam logic [23:0] DIV_MAX = 24'(CLK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [23:0] presc_r;
  logic [23:0] presc_inc_s;
  logic        step_req_d_r;
  logic        adv_s;
  logic [2:0]  code_nxt_s;

  // Next select code for one advance. A code above the range (after 'last'
  // shrank) re-enters the range at its natural start for the direction.
  function automatic logic [2:0] next_code(input logic [2:0] cur,
                                           input logic       down,
                                           input logic [2:0] top);
    logic [2:0] res;
    res = 3'd0;
    if (down) begin
      if ((cur == 3'd0) || (cur > top)) begin
        res = top;
      end else begin
        res = cur - 3'd1;
      end
    end else begin
      if (cur >= top) begin
        res = 3'd0;
      end else begin
        res = cur + 3'd1;
      end
    end
    return res;
  endfunction

  // Mode selection is a pure function of the current enable/mode inputs.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (!en) begin
      state_nxt_s = ST_IDLE;
    end else if (step_mode) begin
      state_nxt_s = ST_STEP;
    end else begin
      state_nxt_s = ST_RUN;
    end
  end

  // Prescaler increment; a count that was not running restarts from zero.
  always_comb begin
    presc_inc_s = 24'd0;
    if ((state_r == ST_RUN) && (presc_r != DIV_MAX)) begin
      presc_inc_s = presc_r + 24'd1;
    end else begin
      presc_inc_s = 24'd0;
    end
  end

  // Advance event as seen by the state currently held; the new mode only
  // governs from the following cycle, so an event coinciding with en falling
  // is still applied.
  always_comb begin
    adv_s = 1'b0;
    case (state_r)
      ST_RUN:  adv_s = tick;
      ST_STEP: adv_s = step_req & ~step_req_d_r;
      ST_IDLE: adv_s = 1'b0;
      default: adv_s = 1'b0;
    endcase
  end

  assign code_nxt_s = next_code(code_out, dir, last);

  // Controller: mode state, prescaler, step edge history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      presc_r      <= 24'd0;
      step_req_d_r <= 1'b0;
      tick         <= 1'b0;
      code_out     <= 3'd0;
      code_valid   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Updated in every state so a level held across a mode switch is not
      // mistaken for a fresh request.
      step_req_d_r <= step_req;
      // Gating on the next state keeps tick confined to cycles spent in RUN,
      // so it can never be seen while in STEP or IDLE.
      if (state_nxt_s == ST_RUN) begin
        presc_r <= presc_inc_s;
        tick    <= (presc_inc_s == DIV_MAX);
      end else begin
        presc_r <= 24'd0;
        tick    <= 1'b0;
      end
      if (adv_s) begin
        code_out   <= code_nxt_s;
        code_valid <= 1'b1;
      end else begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_code_gen.sv
// -----------------------------------------------------------------------------
// tb_scan_code_gen
//
// Directed bench for scan_code_gen with CLK_DIV = 4. Expected codes are queued
// whenever stimulus should cause an advance; a negedge monitor pops one entry
// per code_valid strobe and compares it with code_out.
// -----------------------------------------------------------------------------
module tb_scan_code_gen;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       step_mode;
  logic       step_req;
  logic       dir;
  logic [2:0] last;
  logic [2:0] code_out;
  logic       code_valid;
  logic       tick;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_valid = 0;
  logic [2:0] exp_q[$];
  logic [2:0] sb_exp;
  logic [2:0] t3_seq [0:6] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};

  always #5 clk = ~clk;

  scan_code_gen #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .dir        (dir),
    .last       (last),
    .code_out   (code_out),
    .code_valid (code_valid),
    .tick       (tick)
  );

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every code_valid strobe must match the oldest queued code.
  always @(negedge clk) begin
    if ((rst_n === 1'b1) && (code_valid === 1'b1)) begin
      n_valid++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed strobe with code %0d expected no strobe", code_out);
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        chk3("scoreboard_code", code_out, sb_exp);
      end
    end
  end

  // One cycle; inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valids(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while ((n_valid < target) && (c < budget)) begin
      step();
      c++;
    end
    chk_int(tag, n_valid, target);
  endtask

  // Cycles until tick is seen high, bounded.
  task automatic cycles_to_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while ((tick !== 1'b1) && (cnt < 20));
  endtask

  task automatic pulse_step(input logic [2:0] exp_code);
    exp_q.push_back(exp_code);
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    step();
  endtask

  initial begin
    int cnt;
    int base;

    rst_n     = 1'b0;
    en        = 1'b0;
    step_mode = 1'b0;
    step_req  = 1'b0;
    dir       = 1'b0;
    last      = 3'd7;
    #12;
    chk3("reset_code", code_out, 3'd0);
    chk1("reset_valid", code_valid, 1'b0);
    chk1("reset_tick", tick, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // T2: auto count up through the full range and wrap.
    for (int i = 1; i <= 8; i++) exp_q.push_back(3'(i % 8));
    base = n_valid;
    en = 1'b1;
    cycles_to_tick(cnt);
    chk_int("t2_first_tick_latency", cnt, CLK_DIV);
    cycles_to_tick(cnt);
    chk_int("t2_tick_period", cnt, CLK_DIV);
    wait_valids(base + 8, 60, "t2_valid_count");
    en = 1'b0;
    repeat (3) step();
    chk3("t2_final_code", code_out, 3'd0);
    chk_int("t2_queue_drained", exp_q.size(), 0);

    // T3: auto count down with last=5 from 0.
    last = 3'd5;
    dir  = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(t3_seq[i]);
    base = n_valid;
    en = 1'b1;
    wait_valids(base + 7, 60, "t3_valid_count");
    en = 1'b0;
    repeat (3) step();
    chk3("t3_final_code", code_out, 3'd5);

    // T4: step mode, held request gives one advance, then three pulses.
    dir       = 1'b0;
    last      = 3'd7;
    step_mode = 1'b1;
    en        = 1'b1;
    repeat (2) step();
    base = n_valid;
    exp_q.push_back(3'd6);
    step_req = 1'b1;
    step();
    chk1("t4_step_latency", code_valid, 1'b1);
    repeat (9) step();
    step_req = 1'b0;
    step();
    chk_int("t4_hold_one_advance", n_valid, base + 1);
    chk3("t4_code_after_hold", code_out, 3'd6);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    repeat (3) begin
      step_req = 1'b1;
      step();
      step_req = 1'b0;
      step();
      step();
    end
    chk_int("t4_three_pulses", n_valid, base + 4);
    chk3("t4_code_after_pulses", code_out, 3'd1);

    // T5: range shrink while above the new range, both directions; last=0.
    for (int i = 2; i <= 6; i++) pulse_step(3'(i));
    chk3("t5_code_at_6", code_out, 3'd6);
    last = 3'd3;
    pulse_step(3'd0);
    chk3("t5_shrink_up", code_out, 3'd0);
    last = 3'd7;
    dir  = 1'b1;
    pulse_step(3'd7);
    pulse_step(3'd6);
    last = 3'd3;
    pulse_step(3'd3);
    chk3("t5_shrink_down", code_out, 3'd3);
    last = 3'd0;
    dir  = 1'b0;
    base = n_valid;
    pulse_step(3'd0);
    pulse_step(3'd0);
    chk_int("t5_last0_valids", n_valid, base + 2);
    chk3("t5_last0_code", code_out, 3'd0);

    // T6: en drops in the tick cycle at code 2.
    last      = 3'd7;
    step_mode = 1'b0;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    base = n_valid;
    wait_valids(base + 2, 40, "t6_reach_2");
    cycles_to_tick(cnt);
    chk1("t6_tick_seen", tick, 1'b1);
    chk3("t6_code_at_tick", code_out, 3'd2);
    en = 1'b0;
    exp_q.push_back(3'd3);
    step();
    chk1("t6_valid_on_drop", code_valid, 1'b1);
    chk3("t6_code_on_drop", code_out, 3'd3);
    repeat (10) step();
    chk3("t6_code_held", code_out, 3'd3);
    chk1("t6_tick_idle", tick, 1'b0);
    chk_int("t6_queue_drained", exp_q.size(), 0);
    base = n_valid;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    en = 1'b1;
    cycles_to_tick(cnt);
    chk_int("t6_reenable_tick_latency", cnt, CLK_DIV);
    wait_valids(base + 2, 20, "t6_reach_5");

    // T1: asynchronous reset mid-run with code 5, between clock edges.
    chk3("t1_code_before_reset", code_out, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("t1_async_code", code_out, 3'd0);
    chk1("t1_async_valid", code_valid, 1'b0);
    chk1("t1_async_tick", tick, 1'b0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk3("t1_code_after_release", code_out, 3'd0);
    chk_int("t1_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
